serial_frame_tx: RTL

- Serial frame transmitter. It is the generating side of the team's serial bit-stream Mealy detector: it produces the 1-bit stream X that the detector consumes.
- Accepts a parallel payload word over a valid/ready handshake and emits one frame per word.
- Each frame is a fixed sync preamble, then the payload MSB-first, then idle gap bits. One bit is emitted per bit-strobe (tick).
- Sits between the control logic that produces words and the serial link into the detector.

---
 rtl/serial_frame_pkg.sv | 25 ++
 rtl/frame_piso_shreg.sv | 27 ++
 rtl/serial_frame_tx.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/serial_frame_pkg.sv
// Shared types and defaults for the serial frame link.
// The detector side uses the same preamble constant.
package serial_frame_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PRE  = 2'd1,
        PAY  = 2'd2,
        GAP  = 2'd3
    } state_e;

    localparam int         DEF_DATA_W   = 8;
    localparam int         DEF_PRE_LEN  = 3;
    localparam logic [2:0] DEF_PREAMBLE = 3'b101;
    localparam int         DEF_GAP_LEN  = 2;

    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return (m < 1) ? 1 : $clog2(m + 1);
    endfunction

endpackage

// File: rtl/frame_piso_shreg.sv
// Loadable left-shift register, MSB out, zero fill.
module frame_piso_shreg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         load_i,
    input  logic         shift_i,
    input  logic [W-1:0] data_i,
    output logic         msb_o
);

    logic [W-1:0] data_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q <= '0;
        end else if (load_i) begin
            data_q <= data_i;
        end else if (shift_i) begin
            data_q <= data_q << 1;
        end
    end

    assign msb_o = data_q[W-1];

endmodule

// File: rtl/serial_frame_tx.sv
// Serial frame transmitter: preamble, payload MSB-first, zero gap.
// One bit leaves per sampled tick; output flags are registered.
module serial_frame_tx
    import serial_frame_pkg::*;
#(
    parameter int                 DATA_W   = DEF_DATA_W,
    parameter int                 PRE_LEN  = DEF_PRE_LEN,
    parameter logic [PRE_LEN-1:0] PREAMBLE = PRE_LEN'(DEF_PREAMBLE),
    parameter int                 GAP_LEN  = DEF_GAP_LEN
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              tick,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              x_out,
    output logic              x_valid,
    output logic              busy,
    output logic              frame_done
);

    localparam int CW = cnt_width(PRE_LEN, DATA_W, GAP_LEN);

    localparam logic [CW-1:0] PRE_LAST = CW'(PRE_LEN - 1);
    localparam logic [CW-1:0] PAY_LAST = CW'(DATA_W - 1);
    localparam logic [CW-1:0] GAP_LAST =
        CW'((GAP_LEN > 0) ? GAP_LEN - 1 : 0);

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          x_out_q, x_out_d;
    logic          x_valid_q, x_valid_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          load, shift, sh_msb;
    logic          pre_bit;

    frame_piso_shreg #(
        .W(DATA_W)
    ) u_shreg (
        .clk    (clk),
        .reset_n(reset_n),
        .load_i (load),
        .shift_i(shift),
        .data_i (in_data),
        .msb_o  (sh_msb)
    );

    always_comb begin
        pre_bit = 1'b0;
        for (int i = 0; i < PRE_LEN; i++) begin
            if (cnt_q == CW'(PRE_LEN - 1 - i)) begin
                pre_bit = PREAMBLE[i];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        x_out_d   = x_out_q;
        x_valid_d = 1'b0;
        busy_d    = busy_q;
        done_d    = 1'b0;
        load      = 1'b0;
        shift     = 1'b0;
        unique case (state_q)
            IDLE: begin
                x_out_d = 1'b0;
                if (in_valid) begin
                    state_d = PRE;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    load    = 1'b1;
                end
            end
            PRE: begin
                if (tick) begin
                    x_valid_d = 1'b1;
                    x_out_d   = pre_bit;
                    if (cnt_q == PRE_LAST) begin
                        state_d = PAY;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            PAY: begin
                if (tick) begin
                    x_valid_d = 1'b1;
                    x_out_d   = sh_msb;
                    shift     = 1'b1;
                    if (cnt_q == PAY_LAST) begin
                        cnt_d = '0;
                        if (GAP_LEN == 0) begin
                            state_d = IDLE;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                        end else begin
                            state_d = GAP;
                        end
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            GAP: begin
                if (tick) begin
                    x_valid_d = 1'b1;
                    x_out_d   = 1'b0;
                    if (cnt_q == GAP_LAST) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            x_out_q   <= 1'b0;
            x_valid_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            x_out_q   <= x_out_d;
            x_valid_q <= x_valid_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign in_ready   = (state_q == IDLE);
    assign x_out      = x_out_q;
    assign x_valid    = x_valid_q;
    assign busy       = busy_q;
    assign frame_done = done_q;

endmodule
